// File: rtl/fifo_pkg.sv
// Shared types for the fifo-to-stream unpacker.
// Lane geometry is derived from the word and sample widths.
package fifo_pkg;

  localparam int IN_WIDTH  = 64;
  localparam int OUT_WIDTH = 16;
  localparam int FRAME_W   = 16;
  localparam int LANES     = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W    = $clog2(LANES);

  typedef logic [IN_WIDTH-1:0]  word_t;
  typedef logic [OUT_WIDTH-1:0] sample_t;
  typedef logic [FRAME_W-1:0]   frame_cnt_t;
  typedef logic [LANE_W-1:0]    lane_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } unpack_state_t;

endpackage

// File: rtl/fifo_unpacker_if.sv
// Fifo read side plus sample stream of the unpacker.
// slave is the unpacker's view, master the driver's.
interface fifo_unpacker_if;
  import fifo_pkg::*;

  logic       fifo_empty;
  word_t      fifo_rdata;
  logic       fifo_pop;
  frame_cnt_t frame_len;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  sample_t    out_data;
  logic       out_last;

  modport slave (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_pop,
    input  frame_len,
    input  clear,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport master (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_pop,
    output frame_len,
    output clear,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/fifo_unpacker_frame_counter.sv
// Per-frame sample counter with last-sample flag.
// frame_len of zero means unframed: count wraps, last never set.
module frame_counter
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       accept,
  input  frame_cnt_t frame_len,
  output frame_cnt_t sample_cnt,
  output logic       last
);

  frame_cnt_t r_cnt;

  assign sample_cnt = r_cnt;
  assign last = (frame_len != '0) &&
                (r_cnt == frame_cnt_t'(frame_len - 1'b1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (accept) begin
      r_cnt <= last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_unpacker.sv
// Pops show-ahead fifo words and serialises them LSB lane first.
// A last-lane accept reloads the next word with no bubble.
module fifo_unpacker
  import fifo_pkg::*;
(
  input logic            clk,
  input logic            rst,
  fifo_unpacker_if.slave bus
);

  unpack_state_t r_state;
  unpack_state_t w_state_nxt;
  word_t         r_word;
  word_t         w_word_nxt;
  lane_t         r_lane;
  lane_t         w_lane_nxt;

  sample_t [LANES-1:0] w_lanes;
  logic                w_valid;
  logic                w_accept;
  logic                w_last_lane;
  logic                w_pop;
  logic                w_last;
  frame_cnt_t          w_unused_sample_cnt;

  assign w_lanes     = r_word;
  assign w_valid     = (r_state == SHIFT);
  assign w_accept    = w_valid && bus.out_ready;
  assign w_last_lane = (r_lane == lane_t'(LANES - 1));

  // Reset counts as a flush, so the head is never consumed during it.
  assign w_pop = !bus.fifo_empty && !bus.clear && !rst &&
                 (!w_valid || (w_accept && w_last_lane));

  assign bus.fifo_pop  = w_pop;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_lanes[r_lane] : '0;
  assign bus.out_last  = w_valid && w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_lane_nxt  = r_lane;
    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_lane_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            w_word_nxt  = bus.fifo_rdata;
            w_lane_nxt  = '0;
            w_state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (w_accept) begin
            if (!w_last_lane) begin
              w_lane_nxt = r_lane + 1'b1;
            end else if (w_pop) begin
              w_word_nxt = bus.fifo_rdata;
              w_lane_nxt = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

  frame_counter u_frame (
    .clk        (clk),
    .rst        (rst),
    .clear      (bus.clear),
    .accept     (w_accept),
    .frame_len  (bus.frame_len),
    .sample_cnt (w_unused_sample_cnt),
    .last       (w_last)
  );

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed and random stimulus against a sample-queue model
// of the unpacker, fed by a show-ahead fifo kept as a queue.
module tb_fifo_unpacker;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_unpacker_if bus ();

  fifo_unpacker u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t      fq[$];
  sample_t    cur[$];
  sample_t    seen[$];
  frame_cnt_t scnt;
  int checks = 0;
  int errors = 0;
  int n_pop;
  int n_valid;
  int n_last;
  word_t wa;
  word_t wb;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_pop = 0;
    n_valid = 0;
    n_last = 0;
    seen.delete();
  endtask

  task automatic cyc(input bit check = 1'b1);
    logic    m_valid;
    logic    m_last;
    logic    m_acc;
    logic    m_pop;
    sample_t m_data;
    word_t   head;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
    #1;
    m_valid = (cur.size() != 0);
    m_data  = m_valid ? cur[0] : '0;
    m_last  = m_valid && (bus.frame_len != 0) &&
              (scnt == bus.frame_len - 1);
    m_acc   = m_valid && bus.out_ready;
    m_pop   = (fq.size() != 0) && !bus.clear && !rst &&
              (!m_valid || (m_acc && cur.size() == 1));
    if (check) begin
      chk("pop", bus.fifo_pop, m_pop);
      chk("valid", bus.out_valid, m_valid);
      chk("data", bus.out_data, m_data);
      chk("last", bus.out_last, m_last);
    end
    if (bus.fifo_pop) n_pop++;
    if (bus.out_valid) n_valid++;
    if (bus.out_valid && bus.out_last) n_last++;
    if (bus.out_valid && bus.out_ready && !bus.clear && !rst)
      seen.push_back(bus.out_data);
    @(posedge clk);
    if (rst || bus.clear) begin
      cur.delete();
      scnt = '0;
    end else begin
      if (m_acc) begin
        void'(cur.pop_front());
        scnt = m_last ? '0 : scnt + 1'b1;
      end
      if (m_pop) begin
        head = fq.pop_front();
        for (int i = 0; i < LANES; i++)
          cur.push_back(head[i*OUT_WIDTH +: OUT_WIDTH]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.out_ready = 1'b1;
    bus.frame_len = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    scnt = '0;
    clr_cnt();
    cyc(1'b0);
    cyc();
    rst = 1'b0;

    // idle with empty fifo
    clr_cnt();
    repeat (10) cyc();
    chk("idle_pops", n_pop, 0);
    chk("idle_valid", n_valid, 0);

    // single word
    clr_cnt();
    fq.push_back(64'h0004_0003_0002_0001);
    repeat (8) cyc();
    chk("single_pops", n_pop, 1);
    chk("single_n", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size())
        chk("single_lane", seen[i], i + 1);
    chk("single_last", n_last, 0);

    // back-to-back words
    clr_cnt();
    repeat (3) fq.push_back({$urandom, $urandom});
    repeat (16) cyc();
    chk("b2b_valid", n_valid, 12);
    chk("b2b_pops", n_pop, 3);

    // backpressure on lane 1
    clr_cnt();
    wa = {$urandom, $urandom};
    fq.push_back(wa);
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    repeat (5) cyc();
    bus.out_ready = 1'b1;
    repeat (6) cyc();
    chk("bp_n", seen.size(), 4);
    if (seen.size() > 2)
      chk("bp_lane2", seen[2], wa[32 +: 16]);
    chk("bp_pops", n_pop, 1);

    // flush count, then framed run
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    bus.frame_len = 16'd6;
    clr_cnt();
    repeat (3) fq.push_back({$urandom, $urandom});
    repeat (16) cyc();
    chk("frame_lasts", n_last, 2);
    chk("frame_valid", n_valid, 12);

    // clear during lane 2
    clr_cnt();
    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    fq.push_back(wa);
    fq.push_back(wb);
    cyc();
    cyc();
    cyc();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    repeat (8) cyc();
    chk("clr_pops", n_pop, 2);
    chk("clr_n", seen.size(), 6);
    if (seen.size() > 2)
      chk("clr_new0", seen[2], wb[15:0]);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 4)
        fq.push_back({$urandom, $urandom});
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.clear = ($urandom_range(0, 39) == 0);
      rst = (i == 300);
      if (scnt == 0 && $urandom_range(0, 9) == 0)
        bus.frame_len = frame_cnt_t'($urandom_range(0, 7));
      cyc();
    end
    bus.clear = 1'b0;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
